// File: rtl/decoder_scan_seq_pkg.sv
// Shared types and sizes for the 3-to-8 decoder row-scan sequencer.
package decoder_scan_pkg;

  localparam int ROWS  = 8;
  localparam int ROW_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/decoder_scan_seq_if.sv
// Control and decoder-facing signals of the row-scan sequencer.
interface decoder_scan_seq_if #(
  parameter int DWELL_W = 16
);
  logic               start_i;
  logic               stop_i;
  logic [DWELL_W-1:0] dwell_i;
  logic [7:0]         row_mask_i;
  logic               select_a_o;
  logic               select_b_o;
  logic               select_c_o;
  logic               g1_en_o;
  logic               g2a_en_n_o;
  logic               g2b_en_n_o;
  logic               busy_o;
  logic               frame_done_o;

  modport master (
    output start_i, stop_i, dwell_i, row_mask_i,
    input  select_a_o, select_b_o, select_c_o,
    input  g1_en_o, g2a_en_n_o, g2b_en_n_o, busy_o, frame_done_o
  );

  modport slave (
    input  start_i, stop_i, dwell_i, row_mask_i,
    output select_a_o, select_b_o, select_c_o,
    output g1_en_o, g2a_en_n_o, g2b_en_n_o, busy_o, frame_done_o
  );
endinterface

// File: rtl/decoder_scan_seq_scan_next_row.sv
// Row search over a scan mask: lowest set row, next set row above cur_row
// (wrapping to the lowest), and whether cur_row is the highest set row.
module scan_next_row
  import decoder_scan_pkg::*;
(
  input  logic [ROWS-1:0]  mask,
  input  logic [ROW_W-1:0] cur_row,
  output logic [ROW_W-1:0] next_row,
  output logic [ROW_W-1:0] first_row,
  output logic             is_last
);

  always_comb begin
    first_row = '0;
    next_row  = '0;
    is_last   = 1'b1;
    // Descending scans so the lowest qualifying row is the final assignment.
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (mask[i]) first_row = ROW_W'(i);
    end
    next_row = first_row;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur_row))) begin
        next_row = ROW_W'(i);
        is_last  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/decoder_scan_seq.sv
// Row-scan sequencer driving the select lines and enables of a 74138-style
// decoder, with a blanking gap before every row so selects settle unseen.
//
// state | meaning
// IDLE  | not scanning; enables inactive, select holds last row
// BLANK | enables inactive, select = current row, BLANK_CYCLES long
// DRIVE | enables active for max(dwell, 1) cycles
module decoder_scan_seq
  import decoder_scan_pkg::*;
#(
  parameter int DWELL_W      = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  decoder_scan_seq_if.slave bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_BLANK = BLANK;
  localparam logic [1:0] S_DRIVE = DRIVE;

  localparam logic [3:0] BLANK_LOAD = 4'(BLANK_CYCLES - 1);

  logic [1:0]         state;
  logic [ROW_W-1:0]   row;
  logic [ROWS-1:0]    mask_q;
  logic [3:0]         blank_cnt;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] dwell_load;
  logic               g1_q;
  logic               g2a_n_q;
  logic               g2b_n_q;
  logic               busy_q;
  logic               frame_done_q;

  logic [ROW_W-1:0]   next_row;
  logic [ROW_W-1:0]   first_cur;
  logic               is_last;
  logic [ROW_W-1:0]   first_new;
  logic [ROW_W-1:0]   next_new;
  logic               last_new;
  logic               unused_search;
  logic               new_mask_zero;

  scan_next_row u_cur_search (
    .mask      (mask_q),
    .cur_row   (row),
    .next_row  (next_row),
    .first_row (first_cur),
    .is_last   (is_last)
  );

  scan_next_row u_new_search (
    .mask      (bus.row_mask_i),
    .cur_row   ({ROW_W{1'b0}}),
    .next_row  (next_new),
    .first_row (first_new),
    .is_last   (last_new)
  );

  assign unused_search = ^{first_cur, next_new, last_new};
  assign new_mask_zero = (bus.row_mask_i == '0);

  // Counter holds dwell-1 so the terminal compare at zero gives max(dwell,1).
  assign dwell_load = (bus.dwell_i == '0) ? '0 : bus.dwell_i - DWELL_W'(1);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= S_IDLE;
      row          <= '0;
      mask_q       <= '0;
      blank_cnt    <= '0;
      dwell_cnt    <= '0;
      g1_q         <= 1'b0;
      g2a_n_q      <= 1'b1;
      g2b_n_q      <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start_i && !new_mask_zero) begin
            state     <= S_BLANK;
            mask_q    <= bus.row_mask_i;
            row       <= first_new;
            blank_cnt <= BLANK_LOAD;
            busy_q    <= 1'b1;
          end
        end

        S_BLANK: begin
          if (bus.stop_i) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else if (blank_cnt == 4'd0) begin
            state     <= S_DRIVE;
            dwell_cnt <= dwell_load;
            g1_q      <= 1'b1;
            g2a_n_q   <= 1'b0;
            g2b_n_q   <= 1'b0;
          end else begin
            blank_cnt <= blank_cnt - 4'd1;
          end
        end

        S_DRIVE: begin
          if (bus.stop_i) begin
            state   <= S_IDLE;
            busy_q  <= 1'b0;
            g1_q    <= 1'b0;
            g2a_n_q <= 1'b1;
            g2b_n_q <= 1'b1;
          end else if (dwell_cnt == '0) begin
            g1_q      <= 1'b0;
            g2a_n_q   <= 1'b1;
            g2b_n_q   <= 1'b1;
            blank_cnt <= BLANK_LOAD;
            if (is_last) begin
              // Frame boundary: pick up the live mask for the next frame.
              frame_done_q <= 1'b1;
              mask_q       <= bus.row_mask_i;
              if (new_mask_zero) begin
                state  <= S_IDLE;
                busy_q <= 1'b0;
              end else begin
                state <= S_BLANK;
                row   <= first_new;
              end
            end else begin
              state <= S_BLANK;
              row   <= next_row;
            end
          end else begin
            dwell_cnt <= dwell_cnt - DWELL_W'(1);
          end
        end

        default: begin
          state   <= S_IDLE;
          busy_q  <= 1'b0;
          g1_q    <= 1'b0;
          g2a_n_q <= 1'b1;
          g2b_n_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.select_a_o   = row[0];
  assign bus.select_b_o   = row[1];
  assign bus.select_c_o   = row[2];
  assign bus.g1_en_o      = g1_q;
  assign bus.g2a_en_n_o   = g2a_n_q;
  assign bus.g2b_en_n_o   = g2b_n_q;
  assign bus.busy_o       = busy_q;
  assign bus.frame_done_o = frame_done_q;

endmodule
